// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core's
// load/store port and a word-wide main memory with a req/ack handshake.
module dcache_ctrl #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Loadtype,
    input  logic [1:0]  Storetype,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int WB       = $clog2(WORDS_PER_LINE);
    localparam int WI_W     = (WB > 0) ? WB : 1;
    localparam int IB       = $clog2(NUM_LINES);
    localparam int LINE_OFF = 2 + WB;
    localparam int TAG_W    = 32 - LINE_OFF - IB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    state_e             state_q;
    logic [WI_W-1:0]    cnt_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [NUM_LINES];
    logic [31:0]        data_q [NUM_LINES][WORDS_PER_LINE];
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [3:0]         mem_wstrb_q;

    logic [IB-1:0]      idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [WI_W-1:0]    word_s;
    logic [IB-1:0]      fill_idx_s;
    logic [TAG_W-1:0]   fill_tag_s;
    logic               hit_s;
    logic               store_req_s;
    logic               load_req_s;
    logic               misaligned_s;
    logic               ack_s;
    logic               last_s;
    logic [31:0]        st_wdata_s;
    logic [3:0]         st_wstrb_s;
    logic [31:0]        rd_word_s;
    logic [7:0]         rd_byte_s;
    logic [15:0]        rd_half_s;
    logic [31:0]        ld_data_s;

    assign idx_s = Addr[LINE_OFF +: IB];
    assign tag_s = Addr[31 -: TAG_W];

    generate
        if (WB > 0) begin : g_word_idx
            assign word_s = Addr[2 +: WI_W];
        end else begin : g_single_word
            assign word_s = '0;
        end
    endgenerate

    // The refill target is carried by the held memory address, not by Addr.
    assign fill_idx_s  = mem_addr_q[LINE_OFF +: IB];
    assign fill_tag_s  = mem_addr_q[31 -: TAG_W];
    assign hit_s       = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    assign store_req_s = MemWrite & (Storetype != 2'b11);
    assign load_req_s  = MemRead & ~store_req_s;
    assign ack_s       = mem_ack & mem_req_q;
    assign last_s      = (cnt_q == WI_W'(WORDS_PER_LINE - 1));

    // Alignment check of the active request
    always_comb begin
        misaligned_s = 1'b0;
        if (store_req_s) begin
            case (Storetype)
                2'b01:   misaligned_s = Addr[0];
                2'b10:   misaligned_s = (Addr[1:0] != 2'b00);
                default: misaligned_s = 1'b0;
            endcase
        end else if (MemRead) begin
            case (Loadtype)
                3'b000, 3'b100: misaligned_s = 1'b0;
                3'b001, 3'b101: misaligned_s = Addr[0];
                default:        misaligned_s = (Addr[1:0] != 2'b00);
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // Store lane replication and byte enables
    always_comb begin
        st_wdata_s = 32'h0000_0000;
        st_wstrb_s = 4'b0000;
        case (Storetype)
            2'b00: begin
                st_wdata_s = {4{WriteData[7:0]}};
                st_wstrb_s = 4'b0001 << Addr[1:0];
            end
            2'b01: begin
                st_wdata_s = {2{WriteData[15:0]}};
                st_wstrb_s = 4'b0011 << Addr[1:0];
            end
            2'b10: begin
                st_wdata_s = WriteData;
                st_wstrb_s = 4'b1111;
            end
            default: begin
                st_wdata_s = 32'h0000_0000;
                st_wstrb_s = 4'b0000;
            end
        endcase
    end

    assign rd_word_s = data_q[idx_s][word_s];
    assign rd_byte_s = rd_word_s[{Addr[1:0], 3'b000} +: 8];
    assign rd_half_s = Addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];

    // Load extension
    always_comb begin
        ld_data_s = rd_word_s;
        case (Loadtype)
            3'b000:  ld_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            3'b001:  ld_data_s = {{16{rd_half_s[15]}}, rd_half_s};
            3'b100:  ld_data_s = {24'h00_0000, rd_byte_s};
            3'b101:  ld_data_s = {16'h0000, rd_half_s};
            default: ld_data_s = rd_word_s;
        endcase
    end

    // Core-facing stall and load result
    always_comb begin
        Stall    = 1'b0;
        ReadData = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (misaligned_s) begin
                    Stall = 1'b0;
                end else if (store_req_s) begin
                    Stall = 1'b1;
                end else if (load_req_s && hit_s) begin
                    ReadData = ld_data_s;
                end else if (load_req_s) begin
                    Stall = 1'b1;
                end else begin
                    Stall = 1'b0;
                end
            end
            S_REFILL: Stall = 1'b1;
            S_WRITE:  Stall = ~mem_ack;
            default:  Stall = 1'b0;
        endcase
    end

    // Control FSM, valid bits and the registered memory request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!misaligned_s && store_req_s) begin
                        state_q     <= S_WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {Addr[31:2], 2'b00};
                        mem_wdata_q <= st_wdata_s;
                        mem_wstrb_q <= st_wstrb_s;
                    end else if (!misaligned_s && load_req_s && !hit_s) begin
                        state_q        <= S_REFILL;
                        valid_q[idx_s] <= 1'b0;
                        cnt_q          <= '0;
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= 1'b0;
                        mem_addr_q     <= {Addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
                        mem_wdata_q    <= 32'h0000_0000;
                        mem_wstrb_q    <= 4'b0000;
                    end else begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (ack_s) begin
                        cnt_q <= cnt_q + WI_W'(1);
                        if (last_s) begin
                            valid_q[fill_idx_s] <= 1'b1;
                            state_q             <= S_IDLE;
                            mem_req_q           <= 1'b0;
                        end else begin
                            mem_addr_q <= mem_addr_q + 32'd4;
                        end
                    end
                end
                S_WRITE: begin
                    if (ack_s) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays: store-hit merge and refill fill, never reset
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && !misaligned_s && store_req_s && hit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (st_wstrb_s[b]) begin
                    data_q[idx_s][word_s][8*b +: 8] <= st_wdata_s[8*b +: 8];
                end
            end
        end else if (state_q == S_REFILL && ack_s) begin
            data_q[fill_idx_s][cnt_q] <= mem_rdata;
            if (last_s) begin
                tag_q[fill_idx_s] <= fill_tag_s;
            end
        end
    end

    assign Misaligned = misaligned_s;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a behavioural memory with a two-cycle ack
// records every transaction, which is matched against expected queues.
module tb_dcache_ctrl;
    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [2:0]  Loadtype;
    logic [1:0]  Storetype;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];
    logic [71:0] exp_txn_q [$];
    logic [71:0] obs_txn_q [$];
    logic [31:0] exp_rd_q  [$];

    dcache_ctrl #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .Loadtype(Loadtype), .Storetype(Storetype),
        .ReadData(ReadData), .Stall(Stall), .Misaligned(Misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] txn(input logic we, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] st);
        return {3'b000, we, a, wd, st};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: ack two sampled cycles after a request, one-cycle strobe
    initial begin
        int dly;
        logic [31:0] w;
        dly = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !mem_req) begin
                dly = 0;
                mem_ack = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                dly = 0;
            end else begin
                dly++;
                if (dly == 2) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        obs_txn_q.push_back(txn(1'b1, mem_addr, mem_wdata, mem_wstrb));
                        w = mem_rd(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem[mem_addr] = w;
                    end else begin
                        obs_txn_q.push_back(txn(1'b0, mem_addr, 32'h0, 4'h0));
                        mem_rdata = mem_rd(mem_addr);
                    end
                end
            end
        end
    end

    task automatic exp_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            exp_txn_q.push_back(txn(1'b0, base + 32'(4 * i), 32'h0, 4'h0));
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        exp_txn_q.push_back(txn(1'b1, a, wd, st));
    endtask

    task automatic drain(input string tag);
        while (obs_txn_q.size() > 0 && exp_txn_q.size() > 0)
            check({tag, "_txn"}, obs_txn_q.pop_front(), exp_txn_q.pop_front());
        check({tag, "_extra_txn"}, 72'(obs_txn_q.size()), 72'd0);
        check({tag, "_missing_txn"}, 72'(exp_txn_q.size()), 72'd0);
        obs_txn_q.delete();
        exp_txn_q.delete();
    endtask

    task automatic op(input logic wr, input logic [2:0] lt, input logic [1:0] st,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input string tag, output logic stall_seen);
        int n;
        @(negedge clk);
        MemRead   = ~wr;
        MemWrite  = wr;
        Loadtype  = lt;
        Storetype = st;
        Addr      = a;
        WriteData = wd;
        if (!wr) exp_rd_q.push_back(exp_rd);
        #1;
        stall_seen = Stall;
        n = 0;
        while (Stall && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (Stall) begin
            check({tag, "_timeout"}, 72'(Stall), 72'd0);
            if (!wr) void'(exp_rd_q.pop_front());
        end else if (wr) begin
            check({tag, "_release_on_ack"}, 72'(mem_ack), 72'd1);
        end else begin
            check({tag, "_rdata"}, 72'(ReadData), 72'(exp_rd_q.pop_front()));
        end
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        drain(tag);
    endtask

    initial begin
        logic s;
        int n;
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0;
        WriteData = 32'h0; Loadtype = 3'b010; Storetype = 2'b11;
        mem[32'h100] = 32'h1122_3344;
        mem[32'h104] = 32'h0000_0080;
        #23 rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_mem_req", 72'(mem_req), 72'd0);
        check("rst_mem_we", 72'(mem_we), 72'd0);
        check("rst_stall", 72'(Stall), 72'd0);
        check("rst_rdata", 72'(ReadData), 72'd0);

        exp_refill(32'h100);
        op(1'b0, 3'b010, 2'b11, 32'h100, 32'h0, 32'h1122_3344, "t1_lw", s);
        check("t1_stalled", 72'(s), 72'd1);

        op(1'b0, 3'b000, 2'b11, 32'h103, 32'h0, 32'h0000_0011, "t2_lb", s);
        check("t2_nostall", 72'(s), 72'd0);
        op(1'b0, 3'b000, 2'b11, 32'h104, 32'h0, 32'hFFFF_FF80, "t2_lb_neg", s);
        op(1'b0, 3'b100, 2'b11, 32'h104, 32'h0, 32'h0000_0080, "t2_lbu", s);
        op(1'b0, 3'b101, 2'b11, 32'h102, 32'h0, 32'h0000_1122, "t2_lhu", s);
        op(1'b0, 3'b001, 2'b11, 32'h100, 32'h0, 32'h0000_3344, "t2_lh", s);

        exp_write(32'h100, 32'hABAB_ABAB, 4'b0010);
        op(1'b1, 3'b010, 2'b00, 32'h101, 32'h1234_56AB, 32'h0, "t3_sb", s);
        op(1'b0, 3'b010, 2'b11, 32'h100, 32'h0, 32'h1122_AB44, "t3_lw", s);
        exp_write(32'h104, 32'hBEEF_BEEF, 4'b1100);
        op(1'b1, 3'b010, 2'b01, 32'h106, 32'h7777_BEEF, 32'h0, "t3_sh", s);
        op(1'b0, 3'b001, 2'b11, 32'h106, 32'h0, 32'hFFFF_BEEF, "t3_lh", s);
        op(1'b0, 3'b010, 2'b11, 32'h104, 32'h0, 32'hBEEF_0080, "t3_lw2", s);

        exp_write(32'h400, 32'hCAFE_F00D, 4'b1111);
        op(1'b1, 3'b010, 2'b10, 32'h400, 32'hCAFE_F00D, 32'h0, "t4_sw", s);
        exp_refill(32'h400);
        op(1'b0, 3'b010, 2'b11, 32'h400, 32'h0, 32'hCAFE_F00D, "t4_lw", s);

        op(1'b0, 3'b010, 2'b11, 32'h100, 32'h0, 32'h1122_AB44, "t5_hit", s);
        exp_refill(32'h500);
        op(1'b0, 3'b010, 2'b11, 32'h500, 32'h0, 32'h5A5A_0500, "t5_evict", s);
        exp_refill(32'h100);
        op(1'b0, 3'b010, 2'b11, 32'h100, 32'h0, 32'h1122_AB44, "t5_reread", s);

        @(negedge clk);
        MemRead = 1'b1; Loadtype = 3'b001; Addr = 32'h101;
        #1;
        check("t6_lh_mis", 72'(Misaligned), 72'd1);
        check("t6_lh_stall", 72'(Stall), 72'd0);
        check("t6_lh_rdata", 72'(ReadData), 72'd0);
        repeat (3) @(negedge clk);
        check("t6_lh_noreq", 72'(mem_req), 72'd0);
        MemRead = 1'b0; MemWrite = 1'b1; Storetype = 2'b10; Addr = 32'h102;
        #1;
        check("t6_sw_mis", 72'(Misaligned), 72'd1);
        check("t6_sw_stall", 72'(Stall), 72'd0);
        @(negedge clk);
        check("t6_sw_noreq", 72'(mem_req), 72'd0);
        MemWrite = 1'b0;
        drain("t6_mis");

        @(negedge clk);
        MemRead = 1'b1; Loadtype = 3'b010; Addr = 32'h200;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_refill_req", 72'(mem_req), 72'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_req_drop", 72'(mem_req), 72'd0);
        check("t6_rst_we", 72'(mem_we), 72'd0);
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drain("t6_rst");
        exp_refill(32'h200);
        op(1'b0, 3'b010, 2'b11, 32'h200, 32'h0, 32'h5A5A_0200, "t6_reread", s);
        check("t6_reread_miss", 72'(s), 72'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
